// File: rtl/contador_regresivo.sv
// Loadable down-counter / countdown timer clocked on the falling edge of NEclk.
// Presets from LoadValue, counts to zero, pulses Done, and can auto-reload for periodic timing.
`timescale 1ns/1ps
module contador_regresivo #(
  parameter int BITS = 4
) (
  input  logic            NEclk,
  input  logic            Nreset,
  input  logic            Load,
  input  logic [BITS-1:0] LoadValue,
  input  logic            Start,
  input  logic            Pause,
  input  logic            Abort,
  input  logic            AutoReload,
  output logic [BITS-1:0] count,
  output logic            Running,
  output logic            Done,
  output logic            Zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [BITS-1:0] ZERO_VAL = {BITS{1'b0}};
  localparam logic [BITS-1:0] ONE_VAL  = BITS'(1);

  state_t          state_r, state_s;
  logic [BITS-1:0] count_r, count_s;
  logic [BITS-1:0] reload_r, reload_s;
  logic            done_r, done_s;
  logic            running_r;

  // Next-state logic: Abort beats Load, Load beats the per-state action.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    done_s   = 1'b0;
    if (Abort) begin
      state_s = IDLE;
      count_s = ZERO_VAL;
    end else if (Load) begin
      count_s  = LoadValue;
      reload_s = LoadValue;
      case (state_r)
        IDLE: begin
          if (Start && (LoadValue != ZERO_VAL)) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN:    state_s = RUN;
        PAUSED: state_s = PAUSED;
        DONE: begin
          if (LoadValue != ZERO_VAL) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            if (count_r != ZERO_VAL) begin
              state_s = RUN;
            end else begin
              // A held Start on an empty counter must not stretch the pulse.
              done_s = ~done_r;
            end
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (Pause) begin
            state_s = PAUSED;
          end else if (count_r <= ONE_VAL) begin
            // Terminal count; a zero count in RUN (Load 0 mid-run) also terminates.
            count_s = ZERO_VAL;
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            count_s = count_r - ONE_VAL;
          end
        end
        PAUSED: begin
          if (!Pause) begin
            state_s = RUN;
          end else begin
            state_s = PAUSED;
          end
        end
        DONE: begin
          if (AutoReload && (reload_r != ZERO_VAL)) begin
            count_s = reload_r;
            state_s = RUN;
          end else begin
            count_s = ZERO_VAL;
            state_s = IDLE;
          end
        end
        default: begin
          count_s = ZERO_VAL;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers, updated on the falling edge.
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state_r   <= IDLE;
      count_r   <= ZERO_VAL;
      reload_r  <= ZERO_VAL;
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      reload_r  <= reload_s;
      done_r    <= done_s;
      running_r <= (state_s == RUN);
    end
  end

  assign count   = count_r;
  assign Running = running_r;
  assign Done    = done_r;
  assign Zero    = (count_r == ZERO_VAL);

endmodule

// File: tb/tb_contador_regresivo.sv
// Self-checking bench for contador_regresivo: directed scenarios with literal
// expectations plus randomized stimulus compared every edge against a behavioural model.
`timescale 1ns/1ps
module tb_contador_regresivo;

  localparam int BITS = 4;

  logic            NEclk = 1'b1;
  logic            Nreset = 1'b0;
  logic            Load = 1'b0;
  logic [BITS-1:0] LoadValue = '0;
  logic            Start = 1'b0;
  logic            Pause = 1'b0;
  logic            Abort = 1'b0;
  logic            AutoReload = 1'b0;
  logic [BITS-1:0] count;
  logic            Running;
  logic            Done;
  logic            Zero;

  int total = 0;
  int bad = 0;

  // Behavioural model: mode 0=idle 1=counting 2=paused 3=terminal cycle
  int m_mode = 0;
  int m_count = 0;
  int m_reload = 0;
  int m_done = 0;

  contador_regresivo #(.BITS(BITS)) dut (
    .NEclk(NEclk), .Nreset(Nreset), .Load(Load), .LoadValue(LoadValue),
    .Start(Start), .Pause(Pause), .Abort(Abort), .AutoReload(AutoReload),
    .count(count), .Running(Running), .Done(Done), .Zero(Zero)
  );

  always #10 NEclk = ~NEclk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int prev_done;
    prev_done = m_done;
    m_done = 0;
    if (Abort) begin
      m_count = 0;
      m_mode = 0;
    end else if (Load) begin
      m_count = LoadValue;
      m_reload = LoadValue;
      if (m_mode == 0) m_mode = (Start && LoadValue != 0) ? 1 : 0;
      else if (m_mode == 3) m_mode = (LoadValue != 0) ? 1 : 0;
    end else if (m_mode == 0) begin
      if (Start) begin
        if (m_count != 0) m_mode = 1;
        else m_done = prev_done ? 0 : 1;
      end
    end else if (m_mode == 1) begin
      if (Pause) m_mode = 2;
      else begin
        m_count = (m_count > 0) ? m_count - 1 : 0;
        if (m_count == 0) begin
          m_mode = 3;
          m_done = 1;
        end
      end
    end else if (m_mode == 2) begin
      if (!Pause) m_mode = 1;
    end else begin
      if (AutoReload && m_reload != 0) begin
        m_count = m_reload;
        m_mode = 1;
      end else begin
        m_count = 0;
        m_mode = 0;
      end
    end
  endtask

  // Compare process: update model on every falling edge or reset assertion, then check.
  initial begin
    forever begin
      @(negedge NEclk or negedge Nreset);
      if (!Nreset) begin
        m_mode = 0; m_count = 0; m_reload = 0; m_done = 0;
      end else begin
        model_step();
      end
      #1;
      check("model.count", int'(count), m_count);
      check("model.running", int'(Running), (m_mode == 1) ? 1 : 0);
      check("model.done", int'(Done), m_done);
      check("model.zero", int'(Zero), (m_count == 0) ? 1 : 0);
    end
  end

  task automatic tick(input logic l, input int lv, input logic s, input logic p,
                      input logic a, input logic ar);
    @(posedge NEclk);
    Load = l; LoadValue = lv[BITS-1:0]; Start = s; Pause = p; Abort = a; AutoReload = ar;
    @(negedge NEclk);
    #2;
  endtask

  task automatic expect3(input string name, input int c, input int r, input int d);
    check({name, ".count"}, int'(count), c);
    check({name, ".running"}, int'(Running), r);
    check({name, ".done"}, int'(Done), d);
  endtask

  initial begin
    #15 Nreset = 1'b1;
    check("reset.count", int'(count), 0);
    check("reset.zero", int'(Zero), 1);

    // 1: asynchronous reset mid-run
    tick(1, 5, 1, 0, 0, 0);
    expect3("t1.run5", 5, 1, 0);
    #1 Nreset = 1'b0;
    #2 expect3("t1.async", 0, 0, 0);
    #1 Nreset = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    expect3("t1.after", 0, 0, 0);

    // 2: load 3, start, count down
    tick(1, 3, 0, 0, 0, 0);
    expect3("t2.load", 3, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    expect3("t2.start", 3, 1, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t2.c2", 2, 1, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t2.c1", 1, 1, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t2.c0", 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0); expect3("t2.idle", 0, 0, 0);

    // 3: pause holds count
    tick(1, 4, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t3.c3", 3, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 1, 0, 0);
      expect3("t3.paused", 3, 0, 0);
    end
    tick(0, 0, 0, 0, 0, 0); expect3("t3.resume", 3, 1, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t3.c2", 2, 1, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t3.c1", 1, 1, 0);
    tick(0, 0, 0, 0, 0, 0); expect3("t3.c0", 0, 0, 1);

    // 4: auto-reload, Done every third edge
    tick(1, 2, 1, 0, 0, 1);
    expect3("t4.load", 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0, 0, 1);
      expect3("t4.period", (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2,
              (i % 3 == 1) ? 0 : 1, (i % 3 == 1) ? 1 : 0);
    end
    tick(0, 0, 0, 0, 1, 0);
    expect3("t4.abort", 0, 0, 0);

    // 5: load+start together, then abort beats load
    tick(1, 7, 1, 0, 0, 0); expect3("t5.load_start", 7, 1, 0);
    tick(1, 9, 0, 0, 1, 0); expect3("t5.abort_load", 0, 0, 0);

    // 6: start on empty counter, then full-range countdown
    tick(0, 0, 1, 0, 0, 0); expect3("t6.zero_start", 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0); expect3("t6.zero_after", 0, 0, 0);
    tick(1, 15, 1, 0, 0, 0); expect3("t6.load15", 15, 1, 0);
    for (int i = 0; i < 15; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      expect3("t6.down", 14 - i, (i == 14) ? 0 : 1, (i == 14) ? 1 : 0);
    end
    tick(0, 0, 0, 0, 0, 0); expect3("t6.end", 0, 0, 0);

    // Randomized phase, checked by the compare process every edge
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 7) == 0), $urandom_range(0, 15), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        #1 Nreset = 1'b0;
        #3 Nreset = 1'b1;
      end
    end

    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_regresivo.md
Name: contador_regresivo

Overview:
- Loadable down-counter / countdown timer: the counting-down counterpart of the team's up-counter (contadorN).
- Loads a preset, decrements once per negative clock edge while running, and flags terminal count with a one-cycle Done pulse.
- Optional auto-reload supports periodic timing.
- Sits beside contadorN in the contador block set; same negative-edge clocking and reset style.

Parameters:
BITS, 4, width of count, LoadValue and the internal reload register

Ports:
NEclk  input  1  negative-edge clock; all state changes on falling edge
Nreset  input  1  asynchronous active-low reset
Load  input  1  capture LoadValue into count and reload register
LoadValue  input  BITS  preset value
Start  input  1  begin countdown from IDLE
Pause  input  1  level; hold count while high during RUN/PAUSED
Abort  input  1  return to IDLE, clear count
AutoReload  input  1  level; on terminal count, reload and continue
count  output  BITS  current count, registered
Running  output  1  registered; 1 only in RUN
Done  output  1  registered; one-cycle pulse at terminal count
Zero  output  1  combinational, count == 0

Behaviour:
- Clocking/reset: one clock, NEclk, negative edge. Nreset is asynchronous and active-low.
- Nreset=0 forces immediately, regardless of NEclk: count=0, reload=0, state=IDLE, Running=0, Done=0. Zero therefore reads 1.
- States: IDLE, RUN, PAUSED, DONE.
- Global priority on each falling edge: Abort > Load > state-specific action.
- Abort=1 (any state): count=0, state=IDLE, Done=0. Reload register is kept.
- Load=1 and Abort=0 (any state): count=LoadValue, reload=LoadValue, Done=0, with no decrement that edge.
  - From IDLE with Start=1 on the same edge: go to RUN if LoadValue!=0, else stay IDLE.
  - From IDLE with Start=0: stay IDLE.
  - From RUN/PAUSED: stay in the same state (restart).
  - From DONE: go to RUN if LoadValue!=0, else IDLE.
- IDLE:
  - count holds.
  - Start=1 with count!=0: go to RUN. The first decrement happens on the following edge.
  - Start=1 with count==0: Done=1 for one cycle, stay IDLE.
- RUN:
  - Pause=1: go to PAUSED, count holds.
  - Otherwise count=count-1.
  - If count was 1 (becomes 0): go to DONE and set Done=1 on the same edge.
  - count never underflows in RUN.
- PAUSED:
  - count holds.
  - Pause=0: go back to RUN; decrementing resumes on the next edge.
  - Start is ignored.
- DONE (exactly one cycle, Done=1, count=0):
  - On the next edge Done=0.
  - AutoReload=1 and reload!=0: count=reload, go to RUN (no decrement on the reload edge).
  - Otherwise go to IDLE with count=0.
- Done is high only for the single cycle following a terminal event; never two consecutive cycles.
- Running=1 iff state==RUN, registered with the state.
- Latency: N = loaded value.
  - Start edge: enter RUN.
  - Edges 1..N after it: decrement to 0.
  - The Nth edge asserts Done.
- Arithmetic: unsigned, BITS wide. The maximum preset 2^BITS-1 counts fully with no wrap.
- Pause and Start are sampled only on falling edges. Glitches between edges have no effect.

Test Plan (BITS=4):
1. Nreset low mid-RUN (count=5), between edges -> count=0, Running=0, Done=0 immediately; stays so after release until Load.
2. Load 3, then Start -> Running=1; count 3,2,1,0 on next 3 edges; Done=1 for one cycle with count=0; then IDLE, Running=0.
3. Load 4, Start, Pause high after first decrement (count=3) for 5 edges -> count stays 3, Running=0; release Pause -> 2,1,0, Done pulse.
4. AutoReload=1, Load 2, Start -> count 2,1,0 (Done), 2,1,0 (Done)...; Done pulses exactly every 3 edges.
5. Simultaneous Load 7 + Start in IDLE -> count=7, RUN; Abort + Load same edge in RUN -> count=0, IDLE.
6. Start with count=0 in IDLE -> single Done pulse, state stays IDLE; Load 15, Start -> 15 decrements to 0, no wrap.
